// File: rtl/perf_counter_bank.sv
// Event-counter bank with run/halt gating and registered channel readout.
// Optional shadow snapshot bank: define PERF_SNAPSHOT_EN.
module perf_counter_bank #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 32,
  parameter int SEL_W    = 3,
  parameter int SATURATE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_halt,
  input  logic              i_clr,
  input  logic [NUM_CH-1:0] i_event,
  input  logic              i_snap,
  input  logic [SEL_W-1:0]  i_rd_sel,
  output logic [CNT_W-1:0]  o_rd_data,
  output logic              o_rd_ovf,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic [1:0]        o_state,
  output logic              o_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt [NUM_CH];
  logic [NUM_CH-1:0]  r_ovf;
  logic [CNT_W-1:0]   r_cycle;
  logic [CNT_W-1:0]   r_rd_data;
  logic               r_rd_ovf;
  logic               r_done;

  logic [CNT_W-1:0]   w_cnt_next [NUM_CH];
  logic [NUM_CH-1:0]  w_ovf_next;
  logic [CNT_W-1:0]   w_cycle_next;
  logic [CNT_W-1:0]   w_rd_cnt;
  logic               w_rd_ovf;

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0]   r_shadow [NUM_CH];
`else
  logic               w_unused_snap;
  assign w_unused_snap = i_snap;
`endif

  // Next counter values; the halt cycle itself still counts.
  always_comb begin
    w_cycle_next = r_cycle;
    w_ovf_next   = r_ovf;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_next[i] = r_cnt[i];
    end
    if (r_state == RUN) begin
      if (!(SATURATE != 0 && r_cycle == ALL_ONES)) begin
        w_cycle_next = r_cycle + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_event[i]) begin
          if (r_cnt[i] == ALL_ONES) begin
            w_ovf_next[i] = 1'b1;
          end
          if (!(SATURATE != 0 && r_cnt[i] == ALL_ONES)) begin
            w_cnt_next[i] = r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    w_rd_cnt = '0;
    w_rd_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_rd_sel == SEL_W'(i)) begin
`ifdef PERF_SNAPSHOT_EN
        w_rd_cnt = r_shadow[i];
`else
        w_rd_cnt = r_cnt[i];
`endif
        w_rd_ovf = r_ovf[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_ovf     <= '0;
      r_cycle   <= '0;
      r_rd_data <= '0;
      r_rd_ovf  <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
`ifdef PERF_SNAPSHOT_EN
        r_shadow[i] <= '0;
`endif
      end
    end else begin
      r_rd_data <= w_rd_cnt;
      r_rd_ovf  <= w_rd_ovf;
      if (i_clr) begin
        r_state <= IDLE;
        r_ovf   <= '0;
        r_cycle <= '0;
        r_done  <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          r_cnt[i] <= '0;
`ifdef PERF_SNAPSHOT_EN
          r_shadow[i] <= '0;
`endif
        end
      end else begin
        r_ovf   <= w_ovf_next;
        r_cycle <= w_cycle_next;
        for (int i = 0; i < NUM_CH; i++) begin
          r_cnt[i] <= w_cnt_next[i];
        end
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_state <= RUN;
            end
          end
          RUN: begin
            if (i_halt) begin
              r_state <= HALTED;
              r_done  <= 1'b1;
            end
`ifdef PERF_SNAPSHOT_EN
            // Halt captures final counts; a plain snap captures pre-increment.
            for (int i = 0; i < NUM_CH; i++) begin
              if (i_halt) begin
                r_shadow[i] <= w_cnt_next[i];
              end else if (i_snap) begin
                r_shadow[i] <= r_cnt[i];
              end
            end
`endif
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_rd_ovf      = r_rd_ovf;
  assign o_cycle_count = r_cycle;
  assign o_state       = r_state;
  assign o_done        = r_done;

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Synthesizable, parametrised event-counter bank for the processor's performance instrumentation. It counts retired instructions, cache requests/hits and similar per-cycle event strobes across NUM_CH channels, plus a free-running cycle counter. Counting is gated by a run/halt state machine driven by the processor's halt signal. Results are read back through a registered select port, so counts survive into on-chip readout rather than existing only in simulation.

Parameters:
NUM_CH, 8, number of independent event channels (1..16)
CNT_W, 32, width of every counter including the cycle counter (8..32)
SEL_W, 3, width of rd_sel; 2**SEL_W >= NUM_CH required
SATURATE, 0, 0 = counters wrap on overflow; 1 = counters hold at all-ones

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  pulse: begin counting (IDLE -> RUN)
halt  input  1  processor halt; ends counting (RUN -> HALTED)
clr  input  1  pulse: zero all counters and flags, return to IDLE
event  input  NUM_CH  per-channel event strobe, one count per high cycle
snap  input  1  snapshot request (used only with PERF_SNAPSHOT_EN)
rd_sel  input  SEL_W  channel selected for readout
rd_data  output  CNT_W  registered count of selected channel
rd_ovf  output  1  registered sticky overflow flag of selected channel
cycle_count  output  CNT_W  cycles spent in RUN, including the halt cycle
state  output  2  00 IDLE, 01 RUN, 10 HALTED
done  output  1  high while in HALTED

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all counters, cycle_count, ovf flags, rd_data, rd_ovf, done, and shadow bank = 0.
- Priority per edge: rst > clr > state-machine actions.
- IDLE: events ignored. start=1 -> RUN next cycle. halt is ignored in IDLE, so start and halt together still enter RUN.
- RUN: each cycle, cycle_count += 1. For every i with event[i]=1, cnt[i] += 1. All channels update in parallel and independently.
- halt=1 in RUN -> HALTED next cycle. Events and the cycle in the halt cycle ARE counted, so the halt instruction itself is included.
- HALTED: all counters frozen; done=1. start and halt are ignored. Only clr or rst leaves HALTED.
- clr=1 in any state: zero all counters and ovf flags; state=IDLE next cycle. A simultaneous start is ignored.
- Overflow, SATURATE=0: all-ones + 1 -> 0; ovf[i] is set and stays set until clr/rst.
- Overflow, SATURATE=1: counter stays all-ones; ovf[i] is set on the first attempted increment past all-ones. cycle_count follows the same rule, with no flag.
- Readout: one-cycle latency. rd_data/rd_ovf at edge t+1 show cnt[rd_sel]/ovf[rd_sel] as registered at edge t, i.e. before any increment applied at edge t+1.
- rd_sel >= NUM_CH -> rd_data=0, rd_ovf=0.
- Outputs change only on posedge clk; no combinational path from any input to any output.

Optional Feature:
PERF_SNAPSHOT_EN.
- Defined: adds a shadow bank of NUM_CH x CNT_W registers. snap=1 in RUN copies every live counter (pre-increment value of that cycle) into the shadow bank. Entering HALTED also copies the final counts automatically. rd_data/rd_ovf read the shadow bank; the ovf readout stays live. clr/rst zero the shadow bank.
- Undefined: no shadow bank; snap is ignored; rd_data reads the live counters as described above.

Test Plan:
- Reset, then start; hold event=8'h01 for 10 cycles; assert halt on cycle 10 -> state=10, done=1, cnt[0]=10, cycle_count=10, other channels 0.
- In HALTED, toggle event=8'hFF for 5 cycles and pulse start -> all counts unchanged, state stays 10.
- CNT_W=8, SATURATE=0: 257 events on ch3 -> cnt[3]=1, rd_ovf=1 when rd_sel=3. With SATURATE=1 -> cnt[3]=8'hFF, rd_ovf=1.
- Assert clr and start in the same cycle while in RUN with cnt[2]=7 -> next cycle state=00, cnt[2]=0, cycle_count=0.
- rd_sel=5 set on cycle t -> rd_data valid at t+1; rd_sel=7 with NUM_CH=6 -> rd_data=0.
- PERF_SNAPSHOT_EN: snap at cnt[1]=4, then 3 more events, then halt -> read after snap shows 4; after HALTED shows 7.
